seq_chunk_adder: RTL and testbench

Multi-cycle, parametrised two's-complement adder/subtractor. It processes a WIDTH-bit operand pair CHUNK bits per clock, LSB chunk first, and carries the inter-chunk carry in a register. It generalises the fixed 16-bit ripple adder with configurable width and slice size, a subtract mode, carry-in, a signed-overflow flag and valid/ready handshakes. It sits on the datapath wherever a wide add must meet timing at the cost of WIDTH/CHUNK cycles of latency.

---
 rtl/seq_chunk_adder_if.sv | 27 ++
 rtl/seq_chunk_adder.sv | 126 ++++++++++++
 tb/tb_seq_chunk_adder.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/seq_chunk_adder_if.sv
// Operand/result handshake bundle for seq_chunk_adder.
// The slave side is the adder; the master side issues operands and takes results.
interface seq_chunk_adder_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             carry;
    logic             overflow;

    modport master (
        output in_valid, in1, in2, c_in, sub, out_ready,
        input  in_ready, out_valid, out, carry, overflow
    );

    modport slave (
        input  in_valid, in1, in2, c_in, sub, out_ready,
        output in_ready, out_valid, out, carry, overflow
    );
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle two's-complement adder/subtractor: WIDTH bits processed CHUNK bits
// per clock, LSB slice first, with the inter-slice carry held in a register.
module seq_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    seq_chunk_adder_if.slave    bus
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NCH - 1);
    localparam logic [KW-1:0] K_ONE  = KW'(1);

    generate
        if ((WIDTH < 2) || (CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
            $error("seq_chunk_adder: illegal WIDTH/CHUNK combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic [WIDTH-1:0]  out_r;
    logic              cy_r;
    logic              carry_r;
    logic              ovf_r;
    logic [KW-1:0]     k_r;

    logic [CHUNK-1:0]  a_sl_s;
    logic [CHUNK-1:0]  b_sl_s;
    logic [CHUNK:0]    sum_s;
    logic              msb_cin_s;
    logic              k_last_s;

    // Handshake flags decode straight from the state register.
    assign bus.in_ready  = (state_r == IDLE);
    assign bus.out_valid = (state_r == DONE);
    assign bus.out       = out_r;
    assign bus.carry     = carry_r;
    assign bus.overflow  = ovf_r;

    // One CHUNK-bit ripple slice: the only combinational adder path.
    always_comb begin
        a_sl_s    = a_r[k_r*CHUNK +: CHUNK];
        b_sl_s    = b_r[k_r*CHUNK +: CHUNK];
        sum_s     = {1'b0, a_sl_s} + {1'b0, b_sl_s} + {{CHUNK{1'b0}}, cy_r};
        // Carry into the slice MSB; only meaningful on the final slice.
        msb_cin_s = a_sl_s[CHUNK-1] ^ b_sl_s[CHUNK-1] ^ sum_s[CHUNK-1];
        k_last_s  = (k_r == K_LAST);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) state_s = RUN;
                else              state_s = IDLE;
            end
            RUN: begin
                if (k_last_s) state_s = DONE;
                else          state_s = RUN;
            end
            DONE: begin
                if (bus.out_ready) state_s = IDLE;
                else               state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // Operand capture and slice-by-slice accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            out_r   <= '0;
            cy_r    <= 1'b0;
            carry_r <= 1'b0;
            ovf_r   <= 1'b0;
            k_r     <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        // Subtraction is A + ~B + 1; c_in is ignored in that mode.
                        a_r  <= bus.in1;
                        b_r  <= bus.sub ? ~bus.in2 : bus.in2;
                        cy_r <= bus.sub ? 1'b1 : bus.c_in;
                        k_r  <= '0;
                    end
                end
                RUN: begin
                    out_r[k_r*CHUNK +: CHUNK] <= sum_s[CHUNK-1:0];
                    cy_r                      <= sum_s[CHUNK];
                    if (k_last_s) begin
                        carry_r <= sum_s[CHUNK];
                        ovf_r   <= msb_cin_s ^ sum_s[CHUNK];
                    end else begin
                        k_r <= k_r + K_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed self-checking bench for seq_chunk_adder across several WIDTH/CHUNK settings.
module tb_seq_chunk_adder;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    seq_chunk_adder_if #(.WIDTH(16)) b4  ();
    seq_chunk_adder_if #(.WIDTH(16)) b16 ();
    seq_chunk_adder_if #(.WIDTH(16)) b1  ();
    seq_chunk_adder_if #(.WIDTH(16)) b8  ();
    seq_chunk_adder_if #(.WIDTH(32)) b32 ();

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4))  u_c4  (.clk(clk), .rst_n(rst_n), .bus(b4));
    seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) u_c16 (.clk(clk), .rst_n(rst_n), .bus(b16));
    seq_chunk_adder #(.WIDTH(16), .CHUNK(1))  u_c1  (.clk(clk), .rst_n(rst_n), .bus(b1));
    seq_chunk_adder #(.WIDTH(16), .CHUNK(8))  u_c8  (.clk(clk), .rst_n(rst_n), .bus(b8));
    seq_chunk_adder #(.WIDTH(32), .CHUNK(8))  u_w32 (.clk(clk), .rst_n(rst_n), .bus(b32));

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One operation on the 16/4 instance with out_ready held high.
    task automatic run_c4(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic s, input logic [15:0] e_out,
                          input logic e_c, input logic e_v);
        int lat;
        @(negedge clk);
        b4.in1 = a; b4.in2 = b; b4.c_in = ci; b4.sub = s;
        b4.in_valid = 1'b1; b4.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b4.in_valid = 1'b0;
        b4.in1 = ~a; b4.in2 = ~b; b4.sub = ~s; b4.c_in = ~ci;
        check_val({tag, " busy in_ready"}, 64'(b4.in_ready), 64'd0);
        lat = 0;
        while (!b4.out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check_val({tag, " latency"}, 64'(lat), 64'd4);
        check_val({tag, " out"}, 64'(b4.out), 64'(e_out));
        check_val({tag, " carry"}, 64'(b4.carry), 64'(e_c));
        check_val({tag, " overflow"}, 64'(b4.overflow), 64'(e_v));
        @(posedge clk);
        @(negedge clk);
        check_val({tag, " valid drop"}, 64'(b4.out_valid), 64'd0);
        check_val({tag, " ready back"}, 64'(b4.in_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat16, lat1, lat8, lat32, lat;
        logic iv;

        rst_n = 1'b0;
        b4.in_valid  = 1'b0; b4.in1  = '0; b4.in2  = '0; b4.c_in  = 1'b0; b4.sub  = 1'b0; b4.out_ready  = 1'b0;
        b16.in_valid = 1'b0; b16.in1 = '0; b16.in2 = '0; b16.c_in = 1'b0; b16.sub = 1'b0; b16.out_ready = 1'b0;
        b1.in_valid  = 1'b0; b1.in1  = '0; b1.in2  = '0; b1.c_in  = 1'b0; b1.sub  = 1'b0; b1.out_ready  = 1'b0;
        b8.in_valid  = 1'b0; b8.in1  = '0; b8.in2  = '0; b8.c_in  = 1'b0; b8.sub  = 1'b0; b8.out_ready  = 1'b0;
        b32.in_valid = 1'b0; b32.in1 = '0; b32.in2 = '0; b32.c_in = 1'b0; b32.sub = 1'b0; b32.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset in_ready", 64'(b4.in_ready), 64'd1);
        check_val("reset out_valid", 64'(b4.out_valid), 64'd0);
        check_val("reset out", 64'(b4.out), 64'd0);
        rst_n = 1'b1;

        run_c4("add wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_c4("sub neg",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_c4("sub ovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        run_c4("add ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);

        // Backpressure: result must hold while new operands are offered.
        @(negedge clk);
        b4.in1 = 16'h00FF; b4.in2 = 16'h0F01; b4.c_in = 1'b0; b4.sub = 1'b0;
        b4.in_valid = 1'b1; b4.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        b4.in_valid = 1'b0;
        lat = 0;
        while (!b4.out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check_val("bp latency", 64'(lat), 64'd4);
        iv = 1'b0;
        for (int i = 0; i < 10; i++) begin
            iv = ~iv;
            b4.in_valid = iv;
            b4.in1 = 16'($urandom);
            b4.in2 = 16'($urandom);
            b4.sub = 1'($urandom);
            b4.c_in = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            check_val("bp out", 64'(b4.out), 64'h1000);
            check_val("bp carry", 64'(b4.carry), 64'd0);
            check_val("bp overflow", 64'(b4.overflow), 64'd0);
            check_val("bp in_ready", 64'(b4.in_ready), 64'd0);
            check_val("bp out_valid", 64'(b4.out_valid), 64'd1);
        end
        b4.in_valid = 1'b0;
        b4.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("bp release ready", 64'(b4.in_ready), 64'd1);
        check_val("bp release valid", 64'(b4.out_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check_val("bp no stale accept", 64'(b4.in_ready), 64'd1);

        // Reset two cycles into RUN discards the operation immediately.
        b4.in1 = 16'h1111; b4.in2 = 16'h2222; b4.c_in = 1'b0; b4.sub = 1'b0;
        b4.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b4.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rst out", 64'(b4.out), 64'd0);
        check_val("rst carry", 64'(b4.carry), 64'd0);
        check_val("rst overflow", 64'(b4.overflow), 64'd0);
        check_val("rst out_valid", 64'(b4.out_valid), 64'd0);
        check_val("rst in_ready", 64'(b4.in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_c4("post rst", 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);

        // Parameter sweep, all instances launched on the same edge.
        @(negedge clk);
        b16.in1 = 16'h1234; b16.in2 = 16'h4321; b16.c_in = 1'b1; b16.in_valid = 1'b1;
        b1.in1  = 16'h1234; b1.in2  = 16'h4321; b1.c_in  = 1'b1; b1.in_valid  = 1'b1;
        b8.in1  = 16'h1234; b8.in2  = 16'h4321; b8.c_in  = 1'b1; b8.in_valid  = 1'b1;
        b32.in1 = 32'hFFFFFFFF; b32.in2 = 32'hFFFFFFFF; b32.c_in = 1'b0; b32.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b16.in_valid = 1'b0; b1.in_valid = 1'b0; b8.in_valid = 1'b0; b32.in_valid = 1'b0;
        lat16 = 0; lat1 = 0; lat8 = 0; lat32 = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (b16.out_valid && lat16 == 0) lat16 = n;
            if (b1.out_valid  && lat1  == 0) lat1  = n;
            if (b8.out_valid  && lat8  == 0) lat8  = n;
            if (b32.out_valid && lat32 == 0) lat32 = n;
        end
        check_val("c16 latency", 64'(lat16), 64'd1);
        check_val("c1 latency",  64'(lat1),  64'd16);
        check_val("c8 latency",  64'(lat8),  64'd2);
        check_val("w32 latency", 64'(lat32), 64'd4);
        check_val("c16 out", 64'(b16.out), 64'h5556);
        check_val("c1 out",  64'(b1.out),  64'h5556);
        check_val("c8 out",  64'(b8.out),  64'h5556);
        check_val("c16 carry", 64'(b16.carry), 64'd0);
        check_val("c1 carry",  64'(b1.carry),  64'd0);
        check_val("c8 carry",  64'(b8.carry),  64'd0);
        check_val("w32 out", 64'(b32.out), 64'hFFFFFFFE);
        check_val("w32 carry", 64'(b32.carry), 64'd1);
        check_val("w32 overflow", 64'(b32.overflow), 64'd0);
        b16.out_ready = 1'b1; b1.out_ready = 1'b1; b8.out_ready = 1'b1; b32.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("c1 ready back",  64'(b1.in_ready),  64'd1);
        check_val("w32 ready back", 64'(b32.in_ready), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
